event_count_onehot_enc: RTL and testbench

- Parametrised successor of the single-input registered-event counter with one-hot decode.
- Registers an event input through a configurable synchroniser and counts events in level or rising-edge mode, with wrap or saturate at full scale.
- Publishes a registered one-hot-to-binary encoding of the count with a validity flag instead of X.
- Sits between raw event sources (buttons, game-logic strobes) and display/score logic.

---
 rtl/event_count_onehot_enc_pkg.sv | 39 +++
 rtl/event_count_onehot_enc_onehot_enc.sv | 23 ++
 rtl/event_count_onehot_enc.sv | 107 ++++++++++
 tb/tb_event_count_onehot_enc.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_count_onehot_enc_pkg.sv
// Shared constants, types and the one-hot index helper for the event counter
// and any display block that reuses the encoder.
package event_count_onehot_enc_pkg;

    // EDGE_MODE encodings
    localparam int unsigned MODE_LEVEL = 0;
    localparam int unsigned MODE_EDGE  = 1;

    // SATURATE encodings
    localparam int unsigned OVF_WRAP = 0;
    localparam int unsigned OVF_SAT  = 1;

    // Widest vector the helper accepts; narrower callers zero-extend.
    localparam int unsigned ONEHOT_MAX_W = 64;
    localparam int unsigned IDX_MAX_W    = $clog2(ONEHOT_MAX_W);

    typedef struct packed {
        logic                 valid;
        logic [IDX_MAX_W-1:0] idx;
    } onehot_idx_t;

    // Index of the single set bit plus a validity flag; idx is 0 when the
    // vector is zero or has more than one bit set.
    function automatic onehot_idx_t onehot_to_idx(input logic [ONEHOT_MAX_W-1:0] vec);
        onehot_idx_t res;
        res = '0;
        res.valid = (vec != '0) && ((vec & (vec - ONEHOT_MAX_W'(1))) == '0);
        for (int unsigned i = 0; i < ONEHOT_MAX_W; i++) begin
            if (vec[i]) begin
                res.idx = res.idx | IDX_MAX_W'(i);
            end
        end
        if (!res.valid) begin
            res.idx = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/event_count_onehot_enc_onehot_enc.sv
// Combinational one-hot to binary encoder.
// Ports:
//   vec      - input vector (WIDTH bits, WIDTH <= 64)
//   idx_c    - index of the set bit when vec is one-hot, else 0
//   valid_c  - vec has exactly one bit set
module onehot_enc
    import event_count_onehot_enc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ENC_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [ENC_W-1:0] idx_c,
    output logic             valid_c
);

    onehot_idx_t res;

    assign res     = onehot_to_idx(ONEHOT_MAX_W'(vec));
    assign idx_c   = ENC_W'(res.idx);
    assign valid_c = res.valid;

endmodule

// File: rtl/event_count_onehot_enc.sv
// Event counter with configurable input synchroniser, level/edge counting,
// wrap/saturate overflow handling and a registered one-hot encoding of the count.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   evt_in     - raw event level
//   en         - count enable
//   clr        - synchronous clear of count and status
//   evt_sync   - last synchroniser stage
//   count      - event count
//   ovf        - sticky overflow/saturation flag
//   wrap_pls   - pulse on an increment attempted at all-ones
//   enc        - bit index of count when one-hot (one cycle behind count)
//   enc_valid  - count was exactly one-hot
module event_count_onehot_enc
    import event_count_onehot_enc_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned ENC_W       = $clog2(WIDTH),
    parameter int unsigned SYNC_STAGES = 1,
    parameter int unsigned EDGE_MODE   = MODE_LEVEL,
    parameter int unsigned SATURATE    = OVF_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             evt_in,
    input  logic             en,
    input  logic             clr,
    output logic             evt_sync,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             wrap_pls,
    output logic [ENC_W-1:0] enc,
    output logic             enc_valid
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   evt_d;
    logic                   inc_c;
    logic                   all_ones_c;
    logic [ENC_W-1:0]       enc_idx_c;
    logic                   enc_valid_c;

    assign evt_sync   = sync_q[SYNC_STAGES-1];
    assign all_ones_c = (count == '1);

    // Increment request: level of the synced input, or its rising edge only.
    always_comb begin
        inc_c = 1'b0;
        if (EDGE_MODE == MODE_EDGE) begin
            inc_c = en & evt_sync & ~evt_d;
        end else begin
            inc_c = en & evt_sync;
        end
    end

    onehot_enc #(
        .WIDTH (WIDTH),
        .ENC_W (ENC_W)
    ) u_onehot_enc (
        .vec     (count),
        .idx_c   (enc_idx_c),
        .valid_c (enc_valid_c)
    );

    // Synchroniser, edge history, counter and registered encoder.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '0;
            evt_d     <= 1'b0;
            count     <= '0;
            ovf       <= 1'b0;
            wrap_pls  <= 1'b0;
            enc       <= '0;
            enc_valid <= 1'b0;
        end else begin
            sync_q[0] <= evt_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            evt_d <= evt_sync;

            // Encoder tracks count unconditionally, so clr reaches it a cycle later.
            enc       <= enc_idx_c;
            enc_valid <= enc_valid_c;

            if (clr) begin
                count    <= '0;
                ovf      <= 1'b0;
                wrap_pls <= 1'b0;
            end else if (inc_c) begin
                if (all_ones_c) begin
                    if (SATURATE != OVF_SAT) begin
                        count <= '0;
                    end
                    ovf      <= 1'b1;
                    wrap_pls <= 1'b1;
                end else begin
                    count    <= count + WIDTH'(1);
                    wrap_pls <= 1'b0;
                end
            end else begin
                wrap_pls <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_event_count_onehot_enc.sv
// Directed self-checking bench: level/wrap DUT (defaults), edge DUT with a
// two-stage synchroniser, and a 4-bit saturating DUT.
module tb_event_count_onehot_enc;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Level / wrap instance
    logic       l_evt, l_en, l_clr, l_sync, l_ovf, l_wrap, l_ev;
    logic [7:0] l_cnt;
    logic [2:0] l_enc;
    // Edge instance
    logic       e_evt, e_en, e_clr, e_sync, e_ovf, e_wrap, e_ev;
    logic [7:0] e_cnt;
    logic [2:0] e_enc;
    // Saturating instance
    logic       s_evt, s_en, s_clr, s_sync, s_ovf, s_wrap, s_ev;
    logic [3:0] s_cnt;
    logic [1:0] s_enc;

    event_count_onehot_enc dut_lvl (
        .clk(clk), .rst_n(rst_n), .evt_in(l_evt), .en(l_en), .clr(l_clr),
        .evt_sync(l_sync), .count(l_cnt), .ovf(l_ovf), .wrap_pls(l_wrap),
        .enc(l_enc), .enc_valid(l_ev)
    );

    event_count_onehot_enc #(.SYNC_STAGES(2), .EDGE_MODE(1)) dut_edge (
        .clk(clk), .rst_n(rst_n), .evt_in(e_evt), .en(e_en), .clr(e_clr),
        .evt_sync(e_sync), .count(e_cnt), .ovf(e_ovf), .wrap_pls(e_wrap),
        .enc(e_enc), .enc_valid(e_ev)
    );

    event_count_onehot_enc #(.WIDTH(4), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .evt_in(s_evt), .en(s_en), .clr(s_clr),
        .evt_sync(s_sync), .count(s_cnt), .ovf(s_ovf), .wrap_pls(s_wrap),
        .enc(s_enc), .enc_valid(s_ev)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        l_evt = 1'b1; l_en = 1'b1; l_clr = 1'b0;
        e_evt = 1'b1; e_en = 1'b1; e_clr = 1'b0;
        s_evt = 1'b1; s_en = 1'b1; s_clr = 1'b0;
        repeat (3) step();
        vectors++;
        if ({l_cnt, l_ovf, l_wrap, l_ev, l_enc, l_sync} !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_lvl: got cnt=%0h ovf=%0b wrap=%0b ev=%0b enc=%0d sync=%0b expected all 0",
                     l_cnt, l_ovf, l_wrap, l_ev, l_enc, l_sync);
        end
        vectors++;
        if ({e_cnt, e_ovf, e_wrap, e_ev, e_enc, e_sync} !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_edge: got cnt=%0h ovf=%0b ev=%0b sync=%0b expected all 0",
                     e_cnt, e_ovf, e_ev, e_sync);
        end
        vectors++;
        if ({s_cnt, s_ovf, s_wrap, s_ev, s_enc, s_sync} !== 10'h0) begin
            miscompares++;
            $display("FAIL reset_sat: got cnt=%0h ovf=%0b ev=%0b sync=%0b expected all 0",
                     s_cnt, s_ovf, s_ev, s_sync);
        end
        l_evt = 1'b0; e_evt = 1'b0; s_evt = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_level_count();
        logic       exp_ev;
        logic [2:0] exp_enc;
        l_evt = 1'b1;
        step();  // edge 0: input registered, no count yet
        vectors++;
        if ({l_sync, l_cnt} !== {1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL level_edge0: got sync=%0b cnt=%0d expected sync=1 cnt=0", l_sync, l_cnt);
        end
        for (int k = 1; k <= 5; k++) begin
            l_evt = (k <= 4);
            step();
            vectors++;
            if (l_cnt !== 8'(k)) begin
                miscompares++;
                $display("FAIL level_count k=%0d: got %0d expected %0d", k, l_cnt, k);
            end
            // encoder reflects the count from the previous edge
            exp_ev  = (k == 2) || (k == 3) || (k == 5);
            exp_enc = (k == 3) ? 3'd1 : (k == 5) ? 3'd2 : 3'd0;
            if (k >= 2) begin
                vectors++;
                if ({l_ev, l_enc} !== {exp_ev, exp_enc}) begin
                    miscompares++;
                    $display("FAIL level_enc k=%0d: got ev=%0b enc=%0d expected ev=%0b enc=%0d",
                             k, l_ev, l_enc, exp_ev, exp_enc);
                end
            end
        end
        step();
        vectors++;
        if ({l_cnt, l_ev, l_enc} !== {8'd5, 1'b0, 3'd0}) begin
            miscompares++;
            $display("FAIL level_hold: got cnt=%0d ev=%0b enc=%0d expected cnt=5 ev=0 enc=0", l_cnt, l_ev, l_enc);
        end
        // en low suppresses level increments
        l_evt = 1'b1; l_en = 1'b0;
        repeat (3) step();
        vectors++;
        if (l_cnt !== 8'd5) begin
            miscompares++;
            $display("FAIL level_en_low: got %0d expected 5", l_cnt);
        end
        l_en = 1'b1;
    endtask

    task automatic test_wrap_clr();
        // synced input already high from the previous test: +1 per edge
        repeat (250) step();
        vectors++;
        if ({l_cnt, l_ovf, l_wrap} !== {8'hFF, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL wrap_preload: got cnt=%0h ovf=%0b wrap=%0b expected cnt=ff ovf=0 wrap=0", l_cnt, l_ovf, l_wrap);
        end
        l_evt = 1'b0;
        step();
        vectors++;
        if ({l_cnt, l_ovf, l_wrap} !== {8'h00, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL wrap_event: got cnt=%0h ovf=%0b wrap=%0b expected cnt=0 ovf=1 wrap=1", l_cnt, l_ovf, l_wrap);
        end
        step();
        vectors++;
        if ({l_cnt, l_ovf, l_wrap} !== {8'h00, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL wrap_sticky: got cnt=%0h ovf=%0b wrap=%0b expected cnt=0 ovf=1 wrap=0", l_cnt, l_ovf, l_wrap);
        end
        l_clr = 1'b1;
        step();
        l_clr = 1'b0;
        vectors++;
        if ({l_cnt, l_ovf, l_wrap} !== {8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL wrap_clr: got cnt=%0h ovf=%0b wrap=%0b expected all 0", l_cnt, l_ovf, l_wrap);
        end
    endtask

    task automatic test_clr_priority();
        l_evt = 1'b1;
        step();            // sync
        repeat (7) step(); // count 1..7
        vectors++;
        if (l_cnt !== 8'd7) begin
            miscompares++;
            $display("FAIL clrpri_preload: got %0d expected 7", l_cnt);
        end
        l_clr = 1'b1;      // increment pending in the same cycle
        step();
        l_clr = 1'b0;
        vectors++;
        if (l_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL clrpri_clr_wins: got %0d expected 0", l_cnt);
        end
        step();
        step();
        vectors++;
        if ({l_cnt, l_ev, l_enc} !== {8'd2, 1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL clrpri_resume: got cnt=%0d ev=%0b enc=%0d expected cnt=2 ev=1 enc=0", l_cnt, l_ev, l_enc);
        end
        rst_n = 1'b0; l_clr = 1'b1;
        step();
        rst_n = 1'b1; l_clr = 1'b0; l_evt = 1'b0;
        vectors++;
        if ({l_cnt, l_ovf, l_wrap, l_ev, l_enc, l_sync} !== 15'h0) begin
            miscompares++;
            $display("FAIL clrpri_reset: got cnt=%0h ovf=%0b wrap=%0b ev=%0b enc=%0d sync=%0b expected all 0",
                     l_cnt, l_ovf, l_wrap, l_ev, l_enc, l_sync);
        end
    endtask

    task automatic test_edge_mode();
        e_evt = 1'b0; e_en = 1'b1;
        step();
        e_evt = 1'b1;
        step();  // A: s0=1
        vectors++;
        if ({e_sync, e_cnt} !== {1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL edge_lat_a: got sync=%0b cnt=%0d expected sync=0 cnt=0", e_sync, e_cnt);
        end
        step();  // B: evt_sync rises
        vectors++;
        if ({e_sync, e_cnt} !== {1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL edge_lat_b: got sync=%0b cnt=%0d expected sync=1 cnt=0", e_sync, e_cnt);
        end
        step();  // C: rising edge counted
        vectors++;
        if (e_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL edge_lat_c: got %0d expected 1", e_cnt);
        end
        step();  // D: still high, no further count
        vectors++;
        if (e_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL edge_level_hold: got %0d expected 1", e_cnt);
        end
        e_evt = 1'b0;
        repeat (2) step();
        e_evt = 1'b1;
        step();
        e_evt = 1'b0;
        repeat (4) step();
        vectors++;
        if (e_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL edge_two_edges: got %0d expected 2", e_cnt);
        end
        // third rising edge while disabled is dropped, not deferred
        e_en = 1'b0; e_evt = 1'b1;
        repeat (4) step();
        e_en = 1'b1;
        repeat (3) step();
        vectors++;
        if (e_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL edge_en_drop: got %0d expected 2", e_cnt);
        end
        e_evt = 1'b0;
    endtask

    task automatic test_saturate();
        logic [3:0] exp_cnt;
        logic       exp_ev;
        logic [1:0] exp_enc;
        s_evt = 1'b1;
        step();  // edge 0
        for (int k = 1; k <= 18; k++) begin
            s_evt = (k <= 16);
            step();
            exp_cnt = (k >= 15) ? 4'hF : 4'(k);
            vectors++;
            if ({s_cnt, s_ovf, s_wrap} !== {exp_cnt, (k >= 16), (k == 16 || k == 17)}) begin
                miscompares++;
                $display("FAIL sat k=%0d: got cnt=%0h ovf=%0b wrap=%0b expected cnt=%0h ovf=%0b wrap=%0b",
                         k, s_cnt, s_ovf, s_wrap, exp_cnt, (k >= 16), (k == 16 || k == 17));
            end
            exp_ev  = (k == 2) || (k == 3) || (k == 5) || (k == 9);
            exp_enc = (k == 3) ? 2'd1 : (k == 5) ? 2'd2 : (k == 9) ? 2'd3 : 2'd0;
            if (k >= 2 && k <= 10) begin
                vectors++;
                if ({s_ev, s_enc} !== {exp_ev, exp_enc}) begin
                    miscompares++;
                    $display("FAIL sat_enc k=%0d: got ev=%0b enc=%0d expected ev=%0b enc=%0d",
                             k, s_ev, s_enc, exp_ev, exp_enc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_level_count();
        test_wrap_clr();
        test_clr_priority();
        test_edge_mode();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
